wombat_command_master: RTL and testbench

Host-side initiator for the wombat UART register protocol: accepts register write/read requests on a valid/ready port, serializes them into the protocol byte stream for a UART transmitter, and collects read-response bytes from a UART receiver into one register value. Sits between on-chip test logic (or a bridge to a second board) and a byte-wide UART TX/RX pair, mirroring the parser/register-block slave.

---
 rtl/wombat_cmd_pkg.sv | 16 +
 rtl/wombat_word_shifter.sv | 50 +++++
 rtl/wombat_command_master.sv | 205 ++++++++++++++++++++
 tb/tb_wombat_command_master.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wombat_cmd_pkg.sv
// Shared definitions for the wombat UART register protocol: opcodes and the master state type.
package wombat_cmd_pkg;

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_OP,
    ST_SEND_ADDR,
    ST_SEND_DATA,
    ST_WAIT_RSP,
    ST_FINISH
  } state_e;

endpackage

// File: rtl/wombat_word_shifter.sv
// Register of REG_WIDTH words with parallel load and one-word shift per step.
// LITTLE_ENDIAN=0 moves words toward the MSB end; 1 moves them toward the LSB end.
module wombat_word_shifter #(
  parameter int WORD_WIDTH    = 8,
  parameter int REG_WIDTH     = 4,
  parameter int LITTLE_ENDIAN = 0
) (
  input  logic                             clk,
  input  logic                             reset_i,
  input  logic                             load_i,
  input  logic [WORD_WIDTH*REG_WIDTH-1:0]  value_i,
  input  logic                             shift_i,
  input  logic [WORD_WIDTH-1:0]            word_i,
  output logic [WORD_WIDTH*REG_WIDTH-1:0]  value_o
);

  localparam int VALUE_W = WORD_WIDTH * REG_WIDTH;

  logic [VALUE_W-1:0] data_q;
  logic [VALUE_W-1:0] data_d;
  logic [VALUE_W-1:0] shifted;

  // The word entering at one end is the word that will leave last from the other end.
  if (LITTLE_ENDIAN != 0) begin : g_lsb_first
    assign shifted = (data_q >> WORD_WIDTH) | (VALUE_W'(word_i) << (VALUE_W - WORD_WIDTH));
  end else begin : g_msb_first
    assign shifted = (data_q << WORD_WIDTH) | VALUE_W'(word_i);
  end

  always_comb begin
    data_d = data_q;
    if (load_i) begin
      data_d = value_i;
    end else if (shift_i) begin
      data_d = shifted;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign value_o = data_q;

endmodule

// File: rtl/wombat_command_master.sv
// Host-side initiator for the wombat UART register protocol (request -> byte frame, bytes -> response).
// Define WOMBAT_CMD_TIMEOUT_EN to compile in the read-response timeout (TIMEOUT_CYCLES).
module wombat_command_master
  import wombat_cmd_pkg::*;
#(
  parameter int WORD_WIDTH     = 8,
  parameter int REG_WIDTH      = 4,
  parameter int LITTLE_ENDIAN  = 0,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic                             clk,
  input  logic                             i_reset,
  input  logic                             i_req_valid,
  output logic                             o_req_ready,
  input  logic                             i_req_write,
  input  logic [WORD_WIDTH-1:0]            i_req_addr,
  input  logic [WORD_WIDTH*REG_WIDTH-1:0]  i_req_value,
  output logic                             o_done,
  output logic [WORD_WIDTH*REG_WIDTH-1:0]  o_rsp_value,
  output logic                             o_rsp_error,
  output logic [WORD_WIDTH-1:0]            o_tx_byte,
  output logic                             o_tx_valid,
  input  logic                             i_tx_ready,
  input  logic [WORD_WIDTH-1:0]            i_rx_byte,
  input  logic                             i_rx_valid,
  output logic                             o_busy
);

  localparam int VALUE_W = WORD_WIDTH * REG_WIDTH;
  localparam int CNT_W   = $clog2(REG_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(REG_WIDTH - 1);

  if (REG_WIDTH < 1 || WORD_WIDTH < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("wombat_command_master: WORD_WIDTH, REG_WIDTH and TIMEOUT_CYCLES must be at least 1");
  end

  state_e                  state_q, state_d;
  logic                    write_q, write_d;
  logic [WORD_WIDTH-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [VALUE_W-1:0]      rsp_q, rsp_d;
  logic                    tx_load, tx_shift, rx_shift;
  logic [VALUE_W-1:0]      tx_value, rx_value;
  logic [WORD_WIDTH-1:0]   tx_head;
  logic                    timed_out;

`ifdef WOMBAT_CMD_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             err_q, err_d;
  assign timed_out = err_q;
`else
  assign timed_out = 1'b0;
`endif

  wombat_word_shifter #(
    .WORD_WIDTH   (WORD_WIDTH),
    .REG_WIDTH    (REG_WIDTH),
    .LITTLE_ENDIAN(LITTLE_ENDIAN)
  ) u_tx_shifter (
    .clk    (clk),
    .reset_i(i_reset),
    .load_i (tx_load),
    .value_i(i_req_value),
    .shift_i(tx_shift),
    .word_i ('0),
    .value_o(tx_value)
  );

  wombat_word_shifter #(
    .WORD_WIDTH   (WORD_WIDTH),
    .REG_WIDTH    (REG_WIDTH),
    .LITTLE_ENDIAN(LITTLE_ENDIAN)
  ) u_rx_shifter (
    .clk    (clk),
    .reset_i(i_reset),
    .load_i (1'b0),
    .value_i('0),
    .shift_i(rx_shift),
    .word_i (i_rx_byte),
    .value_o(rx_value)
  );

  assign tx_head = (LITTLE_ENDIAN != 0) ? WORD_WIDTH'(tx_value)
                                        : WORD_WIDTH'(tx_value >> (VALUE_W - WORD_WIDTH));

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_d     = state_q;
    write_d     = write_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    rsp_d       = rsp_q;
    tx_load     = 1'b0;
    tx_shift    = 1'b0;
    rx_shift    = 1'b0;
    o_req_ready = 1'b0;
    o_tx_valid  = 1'b0;
    o_tx_byte   = '0;
    o_done      = 1'b0;
`ifdef WOMBAT_CMD_TIMEOUT_EN
    timer_d     = timer_q;
    err_d       = err_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) begin
          write_d = i_req_write;
          addr_d  = i_req_addr;
          tx_load = 1'b1;
          state_d = ST_SEND_OP;
`ifdef WOMBAT_CMD_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      ST_SEND_OP: begin
        o_tx_valid = 1'b1;
        o_tx_byte  = write_q ? WORD_WIDTH'(OP_WRITE) : WORD_WIDTH'(OP_READ);
        if (i_tx_ready) state_d = ST_SEND_ADDR;
      end
      ST_SEND_ADDR: begin
        o_tx_valid = 1'b1;
        o_tx_byte  = addr_q;
        if (i_tx_ready) begin
          cnt_d   = '0;
          state_d = write_q ? ST_SEND_DATA : ST_WAIT_RSP;
`ifdef WOMBAT_CMD_TIMEOUT_EN
          timer_d = TMR_W'(1);
`endif
        end
      end
      ST_SEND_DATA: begin
        o_tx_valid = 1'b1;
        o_tx_byte  = tx_head;
        if (i_tx_ready) begin
          tx_shift = 1'b1;
          if (cnt_q == LAST_CNT) state_d = ST_FINISH;
          else                   cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT_RSP: begin
        if (i_rx_valid) begin
          rx_shift = 1'b1;
`ifdef WOMBAT_CMD_TIMEOUT_EN
          timer_d  = TMR_W'(1);
`endif
          if (cnt_q == LAST_CNT) state_d = ST_FINISH;
          else                   cnt_d   = cnt_q + CNT_W'(1);
        end
`ifdef WOMBAT_CMD_TIMEOUT_EN
        // The timer holds the cycles elapsed since the last byte (or the address handshake).
        else if (timer_q >= TMR_W'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = ST_FINISH;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
`endif
      end
      ST_FINISH: begin
        o_done  = 1'b1;
        cnt_d   = '0;
        state_d = ST_IDLE;
        if (!write_q && !timed_out) rsp_d = rx_value;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      write_q <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      rsp_q   <= rsp_d;
    end
  end

`ifdef WOMBAT_CMD_TIMEOUT_EN
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      timer_q <= '0;
      err_q   <= 1'b0;
    end else begin
      timer_q <= timer_d;
      err_q   <= err_d;
    end
  end
`endif

  // The freshly assembled word is visible during the done pulse, then held in rsp_q.
  assign o_rsp_value = (state_q == ST_FINISH && !write_q && !timed_out) ? rx_value : rsp_q;
  assign o_rsp_error = timed_out;
  assign o_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_wombat_command_master.sv
// Self-checking bench for wombat_command_master: one MSB-first and one LSB-first instance,
// table vectors, hand-written reset/stray-byte sequences and randomized transactions.
module tb_wombat_command_master;

  localparam int R = 4;
`ifdef WOMBAT_CMD_TIMEOUT_EN
  localparam int TO = 100;
`else
  localparam int TO = 1000;
`endif

  typedef struct {
    int          dut;
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] val;
    logic [31:0] rxw;
    int          n_rx;
    int          pause;
    int          mode;
    logic [47:0] ef;
    int          elen;
    logic [31:0] ersp;
    bit          eerr;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_write [2];
  logic [7:0]  req_addr  [2];
  logic [31:0] req_value [2];
  logic        done      [2];
  logic [31:0] rsp_value [2];
  logic        rsp_error [2];
  logic [7:0]  tx_byte   [2];
  logic        tx_valid  [2];
  logic        tx_ready  [2];
  logic [7:0]  rx_byte   [2];
  logic        rx_valid  [2];
  logic        busy      [2];

  logic [31:0] last_rsp [2];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    wombat_command_master #(
      .WORD_WIDTH(8), .REG_WIDTH(R), .LITTLE_ENDIAN(g), .TIMEOUT_CYCLES(TO)
    ) u_dut (
      .clk(clk), .i_reset(rst),
      .i_req_valid(req_valid[g]), .o_req_ready(req_ready[g]), .i_req_write(req_write[g]),
      .i_req_addr(req_addr[g]), .i_req_value(req_value[g]),
      .o_done(done[g]), .o_rsp_value(rsp_value[g]), .o_rsp_error(rsp_error[g]),
      .o_tx_byte(tx_byte[g]), .o_tx_valid(tx_valid[g]), .i_tx_ready(tx_ready[g]),
      .i_rx_byte(rx_byte[g]), .i_rx_valid(rx_valid[g]), .o_busy(busy[g])
    );
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: protocol frame as bytes, first byte in the top bits.
  function automatic logic [47:0] model_frame(bit le, bit wr, logic [7:0] addr, logic [31:0] val);
    logic [47:0] f;
    f = {(wr ? 8'h57 : 8'h52), addr, 32'h0};
    if (wr) begin
      for (int i = 0; i < R; i++) begin
        int sh = le ? 8 * i : 8 * (R - 1 - i);
        f[31 - 8 * i -: 8] = 8'((val >> sh) & 32'hFF);
      end
    end
    return f;
  endfunction

  function automatic logic [31:0] model_rsp(bit le, logic [31:0] rxw);
    logic [31:0] v = 32'h0;
    for (int i = 0; i < R; i++) begin
      logic [7:0] b = rxw[31 - 8 * i -: 8];
      if (le) v = v | (32'(b) << (8 * i));
      else    v = (v << 8) | 32'(b);
    end
    return v;
  endfunction

  function automatic vec_t mk(int dut, bit wr, logic [7:0] addr, logic [31:0] val,
                              logic [31:0] rxw, int n_rx, int pause, int mode,
                              logic [47:0] ef, logic [31:0] ersp, bit eerr);
    vec_t v;
    v.dut = dut; v.wr = wr; v.addr = addr; v.val = val; v.rxw = rxw; v.n_rx = n_rx;
    v.pause = pause; v.mode = mode; v.ef = ef; v.elen = wr ? 2 + R : 2;
    v.ersp = ersp; v.eerr = eerr;
    return v;
  endfunction

  task automatic run_txn(input vec_t v, input string tag);
    int d = v.dut;
    logic [7:0] got [$];
    logic [31:0] want_rsp;
    int k, sent, fed, gap, last_rx_k, done_k;
    bit prev_stall, rdy;
    logic [7:0] prev_byte;

    want_rsp = (v.wr || v.eerr) ? last_rsp[d] : v.ersp;
    k = 0;
    while (req_ready[d] !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check({tag, " req_ready idle"}, req_ready[d], 1);
    req_valid[d] = 1'b1; req_write[d] = v.wr; req_addr[d] = v.addr; req_value[d] = v.val;
    @(negedge clk);
    req_valid[d] = 1'b0; req_value[d] = $urandom; req_addr[d] = 8'($urandom);
    k = 1; sent = 0; fed = 0; gap = $urandom_range(0, 3); last_rx_k = 0; done_k = 0;
    prev_stall = 1'b0; prev_byte = 8'h0;
    while (k < 3000) begin
      if (done[d] === 1'b1) begin
        done_k = k;
        break;
      end
      if (prev_stall) begin
        check({tag, " stall valid"}, tx_valid[d], 1);
        check({tag, " stall byte"}, tx_byte[d], prev_byte);
      end
      rx_valid[d] = 1'b0;
      rx_byte[d]  = 8'($urandom);
      if (!v.wr && sent == v.elen) begin
        if (fed < v.n_rx) begin
          if (gap == 0) begin
            rx_valid[d] = 1'b1;
            rx_byte[d]  = v.rxw[31 - 8 * fed -: 8];
            fed++;
            last_rx_k = k;
            gap = (fed == 2) ? v.pause : $urandom_range(0, 3);
          end else begin
            gap--;
          end
        end
      end else if ($urandom_range(0, 3) == 0) begin
        rx_valid[d] = 1'b1;
      end
      rdy = (v.mode == 0) ? 1'b1 : (v.mode == 1) ? (k % 2 == 1) : 1'($urandom_range(0, 1));
      tx_ready[d] = rdy;
      prev_stall = (tx_valid[d] === 1'b1) && !rdy;
      prev_byte  = tx_byte[d];
      if (tx_valid[d] === 1'b1 && rdy) begin
        got.push_back(tx_byte[d]);
        sent++;
      end
      @(negedge clk);
      k++;
    end
    rx_valid[d] = 1'b0;
    tx_ready[d] = 1'b0;
    check({tag, " done seen"}, (done_k != 0), 1);
    if (v.wr && v.mode == 0) check({tag, " done cycle"}, done_k, 3 + R);
    if (!v.wr) check({tag, " done cycle"}, done_k, last_rx_k + (v.eerr ? TO : 1));
    check({tag, " rsp_error"}, rsp_error[d], v.eerr);
    check({tag, " rsp_value"}, rsp_value[d], want_rsp);
    check({tag, " busy at done"}, busy[d], 1);
    check({tag, " req_ready at done"}, req_ready[d], 0);
    check({tag, " byte count"}, got.size(), v.elen);
    for (int i = 0; i < v.elen && i < got.size(); i++)
      check({tag, $sformatf(" byte %0d", i)}, got[i], v.ef[47 - 8 * i -: 8]);
    last_rsp[d] = want_rsp;
    @(negedge clk);
    check({tag, " done pulse width"}, done[d], 0);
    check({tag, " req_ready after"}, req_ready[d], 1);
    check({tag, " busy after"}, busy[d], 0);
    check({tag, " rsp_value held"}, rsp_value[d], want_rsp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [$];
    vec_t v;
    bit wr;
    logic [7:0] a;
    logic [31:0] val, rxw;
    int d;

    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_write[i] = 1'b0; req_addr[i] = 8'h0; req_value[i] = 32'h0;
      tx_ready[i] = 1'b0; rx_byte[i] = 8'h0; rx_valid[i] = 1'b0; last_rsp[i] = 32'h0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("reset%0d tx_valid", i), tx_valid[i], 0);
      check($sformatf("reset%0d tx_byte", i), tx_byte[i], 0);
      check($sformatf("reset%0d done", i), done[i], 0);
      check($sformatf("reset%0d rsp_value", i), rsp_value[i], 0);
      check($sformatf("reset%0d rsp_error", i), rsp_error[i], 0);
      check($sformatf("reset%0d busy", i), busy[i], 0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("post-reset req_ready", req_ready[0], 1);

    // Table vectors.
    tbl.push_back(mk(0, 1, 8'h03, 32'hDEADBEEF, 0, 0, 0, 0, 48'h5703_DEAD_BEEF, 0, 0));
    tbl.push_back(mk(1, 1, 8'h03, 32'hDEADBEEF, 0, 0, 0, 1, 48'h5703_EFBE_ADDE, 0, 0));
    tbl.push_back(mk(0, 0, 8'h01, 0, 32'h12345678, 4, 3, 0, 48'h5201_0000_0000, 32'h12345678, 0));
    tbl.push_back(mk(1, 0, 8'h01, 0, 32'h12345678, 4, 2, 2, 48'h5201_0000_0000, 32'h78563412, 0));
`ifdef WOMBAT_CMD_TIMEOUT_EN
    tbl.push_back(mk(0, 0, 8'h7F, 0, 32'h0A0B0C0D, 2, 0, 0, 48'h527F_0000_0000, 0, 1));
`else
    tbl.push_back(mk(0, 0, 8'h7F, 0, 32'h0A0B0C0D, 4, 150, 0, 48'h527F_0000_0000, 32'h0A0B0C0D, 0));
`endif
    tbl.push_back(mk(1, 1, 8'hFF, 32'h0, 0, 0, 0, 2, 48'h57FF_0000_0000, 0, 0));
    tbl.push_back(mk(0, 1, 8'h40, 32'h01020304, 0, 0, 0, 0, 48'h5740_0102_0304, 0, 0));
    foreach (tbl[i]) run_txn(tbl[i], $sformatf("vec%0d", i));

    // Stray byte while idle must be ignored by the following read.
    rx_byte[0] = 8'hAA; rx_valid[0] = 1'b1;
    @(negedge clk);
    rx_valid[0] = 1'b0;
    check("stray idle busy", busy[0], 0);
    run_txn(mk(0, 0, 8'h20, 0, 32'h00000005, 4, 0, 0, 48'h5220_0000_0000, 32'h5, 0), "stray");

    // Reset in the middle of SEND_DATA.
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 8'h11; req_value[0] = 32'hDEADBEEF;
    tx_ready[0] = 1'b1;
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midframe data0", tx_byte[0], 8'hDE);
    check("midframe busy", busy[0], 1);
    #1 rst = 1'b1;
    #1;
    check("midreset tx_valid", tx_valid[0], 0);
    check("midreset tx_byte", tx_byte[0], 0);
    check("midreset done", done[0], 0);
    check("midreset rsp_value", rsp_value[0], 0);
    check("midreset rsp_value le", rsp_value[1], 0);
    check("midreset rsp_error", rsp_error[0], 0);
    check("midreset busy", busy[0], 0);
    @(negedge clk);
    rst = 1'b0;
    tx_ready[0] = 1'b0;
    last_rsp[0] = 32'h0;
    last_rsp[1] = 32'h0;
    run_txn(mk(0, 1, 8'h00, 32'h1, 0, 0, 0, 0, 48'h5700_0000_0001, 0, 0), "after-reset");

    // Randomized transactions against the reference model.
    for (int i = 0; i < 40; i++) begin
      d   = $urandom_range(0, 1);
      wr  = 1'($urandom_range(0, 1));
      a   = 8'($urandom);
      val = $urandom;
      rxw = $urandom;
      v = mk(d, wr, a, val, rxw, 4, $urandom_range(0, 3), $urandom_range(0, 2),
             model_frame(d == 1, wr, a, val), model_rsp(d == 1, rxw), 0);
      run_txn(v, $sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
